mc_rd_issue: RTL and testbench
==============================

# mc_rd_issue

Read-command issuer between the read-address ROM and the MIG user port. Latches the current address from the address source and issues a single-word read command. It captures the returned word, hands it downstream (SPART transmit path) over a valid/ready handshake, then pulses `mc_rd_rdy` so the address source advances to its next entry. It tolerates a stalled command FIFO and a non-responding memory via a watchdog, and discards stale read data after reset.

## Interface
- `ADDR_W`, 31: width of `addr_in` and `cmd_addr`.
- `DATA_W`, 32: width of `rd_data` and `out_data`.
- `TIMEOUT`, 1024: cycles to wait in WAIT for read data before abandoning the request; must be ≥ 2.

- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  level enable; while high, back-to-back reads are issued.
- `addr_in`  in  ADDR_W  current address from the address source; stable except the cycle after `mc_rd_rdy`.
- `mc_rd_rdy`  out  1  one-cycle pulse: request consumed, advance address source.
- `cmd_full`  in  1  MIG command FIFO full.
- `cmd_en`  out  1  command write strobe.
- `cmd_instr`  out  3  constant 3'b001 (read).
- `cmd_addr`  out  ADDR_W  latched request address.
- `rd_empty`  in  1  MIG read FIFO empty; first-word-fall-through, so `rd_data` is valid whenever low.
- `rd_en`  out  1  read FIFO pop.
- `rd_data`  in  DATA_W  read FIFO head.
- `out_data`  out  DATA_W  captured word to downstream.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts.
- `busy`  out  1  state ≠ IDLE.
- `err`  out  1  sticky timeout flag.
- `rd_count`  out  16  completed reads (handshakes on out), wraps at 16'hFFFF→0.

## Operation
- States: IDLE, CMD, WAIT, OUT, ADV.
- IDLE
  - If `rd_empty`=0: `rd_en`=1 and the word is discarded (drain of stale or late data); `start` is ignored that cycle.
  - Else if `start`=1: `addr_q`←`addr_in`, go to CMD.
- CMD: `cmd_en` = !`cmd_full`; `cmd_addr`=`addr_q` throughout. On `cmd_en`=1 → WAIT, clear watchdog. While `cmd_full`, hold indefinitely; there is no timeout in CMD.
- WAIT
  - If `rd_empty`=0: `rd_en`=1, `out_data`←`rd_data`, → OUT.
  - Else the watchdog increments. When it reaches TIMEOUT-1 with `rd_empty` still 1: `err`←1, → ADV, and the address is skipped.
  - Data arriving on the timeout cycle wins over the timeout.
- OUT: `out_valid`=1. On `out_ready`=1: `rd_count`++, → ADV. `out_data` is held stable while waiting.
- ADV: `mc_rd_rdy`=1 for exactly this cycle, → IDLE.
- `cmd_en`, `rd_en`, `mc_rd_rdy`, `out_valid`, `busy` are decoded from state plus the `cmd_full`/`rd_empty` inputs. `out_data`, `addr_q`, `err`, `rd_count` are registers.
- Deasserting `start` mid-request does not abort it; the request completes through ADV and the block then idles.
- `err` clears only on `rst`.
- Exactly one `cmd_en` and at most one `mc_rd_rdy` per request; one `rd_en` per accepted word.

## Timing
- Reset values: state IDLE, `out_data`=0, `err`=0, `rd_count`=0, `addr_q`=0. Outputs `cmd_en`, `rd_en`, `out_valid`, `mc_rd_rdy`, `busy` are 0 except `rd_en`, which follows the IDLE drain rule from the first post-reset cycle.
- `rst` mid-operation returns to IDLE next edge. Any command already issued has its data drained in IDLE.
- Best-case request, no stalls, data in the cycle after `cmd_en`, `out_ready` tied high:
  - IDLE(latch) at cycle 0.
  - CMD with `cmd_en` at 1.
  - WAIT with `rd_en` at 2.
  - OUT with `out_valid` at 3.
  - ADV with `mc_rd_rdy` at 4.
  - IDLE at 5.
  - Period 5 cycles/read.
- The address source updates on the edge ending ADV; the IDLE latch one cycle later sees the new address.
- Timeout: `err` is high the cycle after TIMEOUT cycles spent in WAIT, and ADV follows in that same cycle.

## Test plan
- Reset then `start`=1, memory returns `addr`+0xA5A5_0000 one cycle after each command, `out_ready`=1: nine `cmd_addr` values 0x1000…0x1020 then 0x1000 again, 5-cycle period, `rd_count`=10 after 10 reads, `err`=0.
- `cmd_full`=1 for 7 cycles in CMD: `cmd_en` stays 0 for those 7 cycles, then exactly one pulse; no `mc_rd_rdy` until data is delivered.
- `out_ready`=0 for 4 cycles in OUT: `out_valid` held and `out_data` unchanged; `rd_count` increments once.
- TIMEOUT=8, memory silent: `err`=1 after 8 WAIT cycles and `mc_rd_rdy` pulses. A late word injected 3 cycles later is drained in IDLE (`rd_en`=1, no `out_valid`) before the next `cmd_en`.
- `rst` asserted in WAIT with data arriving 2 cycles after reset: all outputs return to reset values, the stale word is popped, and the first `out_data` after the next `start` matches the new address.

Source files
------------

// File: rtl/mc_rd_issue.sv
// mc_rd_issue: issues one single-word MIG read per address-source entry,
// forwards the returned word over a valid/ready port, then pulses mc_rd_rdy
// so the address source advances. A watchdog abandons reads the memory never
// answers, and words that show up while idle are drained and dropped.
module mc_rd_issue #(
  parameter int ADDR_W  = 31,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              mc_rd_rdy,
  input  logic              cmd_full,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              rd_empty,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err,
  output logic [15:0]       rd_count
);

  // Watchdog only has to count up to TIMEOUT-1.
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT,
    S_OUT,
    S_ADV
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  // Next-state logic and the strobes decoded from state plus FIFO flags.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    cmd_en    = 1'b0;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    mc_rd_rdy = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Anything in the read FIFO now belongs to an abandoned or
        // pre-reset request; pop it before accepting new work.
        if (!rd_empty) begin
          rd_en = 1'b1;
        end else if (start) begin
          addr_d  = addr_in;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        // A full command FIFO stalls here with no time limit.
        if (!cmd_full) begin
          cmd_en  = 1'b1;
          wd_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Data on the final watchdog cycle still counts as a good read.
        if (!rd_empty) begin
          rd_en   = 1'b1;
          data_d  = rd_data;
          state_d = S_OUT;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_ADV;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = S_ADV;
        end
      end
      S_ADV: begin
        mc_rd_rdy = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign cmd_instr = 3'b001;
  assign cmd_addr  = addr_q;
  assign out_data  = data_q;
  assign err       = err_q;
  assign rd_count  = cnt_q;

endmodule

// File: tb/tb_mc_rd_issue.sv
// Directed bench for mc_rd_issue: address ROM and MIG read FIFO models
// around the DUT, cycle-exact checks of every strobe and register.
module tb_mc_rd_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [30:0] addr_in;
  logic        mc_rd_rdy;
  logic        cmd_full;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [30:0] cmd_addr;
  logic        rd_empty;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        err;
  logic [15:0] rd_count;

  int checks = 0;
  int errors = 0;

  // Memory model state
  logic        fifo_vld   = 1'b0;
  logic [31:0] fifo_data  = '0;
  logic [31:0] cdata      = '0;
  int          lat_cnt    = 0;
  int          mem_lat    = 1;
  logic        mem_silent = 1'b0;
  int          inj_req    = 0;
  int          inj_done   = 0;
  logic [31:0] inj_data   = '0;
  int          idx        = 0;

  logic [30:0] exp_a [10];
  logic [31:0] exp_d [10];

  always #5 clk = ~clk;

  mc_rd_issue #(.ADDR_W(31), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .addr_in   (addr_in),
    .mc_rd_rdy (mc_rd_rdy),
    .cmd_full  (cmd_full),
    .cmd_en    (cmd_en),
    .cmd_instr (cmd_instr),
    .cmd_addr  (cmd_addr),
    .rd_empty  (rd_empty),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err),
    .rd_count  (rd_count)
  );

  // Address ROM: nine entries 0x1000..0x1020, advanced by mc_rd_rdy.
  assign addr_in = 31'h1000 + 31'(idx * 4);
  always @(posedge clk) begin
    if (rst) idx <= 0;
    else if (mc_rd_rdy) idx <= (idx == 8) ? 0 : idx + 1;
  end

  // MIG read FIFO: answers a command after mem_lat cycles with addr+0xA5A50000.
  assign rd_empty = !fifo_vld;
  assign rd_data  = fifo_data;
  always @(posedge clk) begin
    if (rd_en && fifo_vld) fifo_vld <= 1'b0;
    if (cmd_en && !mem_silent) begin
      if (mem_lat <= 1) begin
        fifo_vld  <= 1'b1;
        fifo_data <= 32'(cmd_addr) + 32'hA5A5_0000;
      end else begin
        lat_cnt <= mem_lat - 1;
        cdata   <= 32'(cmd_addr) + 32'hA5A5_0000;
      end
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        fifo_vld  <= 1'b1;
        fifo_data <= cdata;
      end
    end
    if (inj_req != inj_done) begin
      fifo_vld  <= 1'b1;
      fifo_data <= inj_data;
      inj_done  <= inj_req;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // go: just after a rising edge, where inputs for the new cycle are driven.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  // look: mid-cycle sample point.
  task automatic look();
    @(negedge clk);
  endtask

  task automatic cyc();
    go();
    look();
  endtask

  initial begin
    exp_a = '{31'h1000, 31'h1004, 31'h1008, 31'h100C, 31'h1010,
              31'h1014, 31'h1018, 31'h101C, 31'h1020, 31'h1000};
    exp_d = '{32'hA5A5_1000, 32'hA5A5_1004, 32'hA5A5_1008, 32'hA5A5_100C, 32'hA5A5_1010,
              32'hA5A5_1014, 32'hA5A5_1018, 32'hA5A5_101C, 32'hA5A5_1020, 32'hA5A5_1000};
    rst = 1'b1; start = 1'b0; cmd_full = 1'b0; out_ready = 1'b1;

    // Reset state
    cyc();
    cyc();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cmd_en", 64'(cmd_en), 64'(0));
    chk("rst_rd_en", 64'(rd_en), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mc_rd_rdy", 64'(mc_rd_rdy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_rd_count", 64'(rd_count), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_cmd_addr", 64'(cmd_addr), 64'(0));
    chk("cmd_instr", 64'(cmd_instr), 64'(3'b001));

    // Ten back-to-back reads, 5-cycle period
    go(); rst = 1'b0; start = 1'b1; look();
    chk("t1_idle", 64'(busy), 64'(0));
    for (int r = 0; r < 10; r++) begin
      cyc();
      chk("t1_cmd_en", 64'(cmd_en), 64'(1));
      chk("t1_cmd_addr", 64'(cmd_addr), 64'(exp_a[r]));
      cyc();
      chk("t1_rd_en", 64'(rd_en), 64'(1));
      chk("t1_wait_cmd_en", 64'(cmd_en), 64'(0));
      cyc();
      chk("t1_out_valid", 64'(out_valid), 64'(1));
      chk("t1_out_data", 64'(out_data), 64'(exp_d[r]));
      go(); if (r == 9) start = 1'b0; look();
      chk("t1_mc_rd_rdy", 64'(mc_rd_rdy), 64'(1));
      chk("t1_rd_count", 64'(rd_count), 64'(r + 1));
      cyc();
      chk("t1_back_idle", 64'(busy), 64'(0));
    end
    cyc();
    chk("t1_stays_idle", 64'(busy), 64'(0));
    chk("t1_count10", 64'(rd_count), 64'(10));
    chk("t1_err", 64'(err), 64'(0));

    // Command FIFO full for 7 cycles
    go(); start = 1'b1; cmd_full = 1'b1; look();
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("t2_stall_cmd_en", 64'(cmd_en), 64'(0));
      chk("t2_stall_busy", 64'(busy), 64'(1));
      chk("t2_stall_rdy", 64'(mc_rd_rdy), 64'(0));
    end
    go(); cmd_full = 1'b0; start = 1'b0; look();
    chk("t2_cmd_en", 64'(cmd_en), 64'(1));
    chk("t2_cmd_addr", 64'(cmd_addr), 64'(31'h1004));
    cyc();
    chk("t2_wait_cmd_en", 64'(cmd_en), 64'(0));
    chk("t2_rd_en", 64'(rd_en), 64'(1));
    chk("t2_wait_rdy", 64'(mc_rd_rdy), 64'(0));
    cyc();
    chk("t2_out_data", 64'(out_data), 64'(32'hA5A5_1004));
    cyc();
    chk("t2_mc_rd_rdy", 64'(mc_rd_rdy), 64'(1));
    cyc();
    chk("t2_idle", 64'(busy), 64'(0));
    chk("t2_count", 64'(rd_count), 64'(11));

    // Downstream stalls for 4 cycles
    go(); start = 1'b1; out_ready = 1'b0; look();
    cyc();
    chk("t3_cmd_addr", 64'(cmd_addr), 64'(31'h1008));
    go(); start = 1'b0; look();
    chk("t3_rd_en", 64'(rd_en), 64'(1));
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_hold_valid", 64'(out_valid), 64'(1));
      chk("t3_hold_data", 64'(out_data), 64'(32'hA5A5_1008));
      chk("t3_hold_count", 64'(rd_count), 64'(11));
      chk("t3_hold_rdy", 64'(mc_rd_rdy), 64'(0));
    end
    go(); out_ready = 1'b1; look();
    chk("t3_accept_valid", 64'(out_valid), 64'(1));
    cyc();
    chk("t3_mc_rd_rdy", 64'(mc_rd_rdy), 64'(1));
    chk("t3_count", 64'(rd_count), 64'(12));
    cyc();
    chk("t3_idle", 64'(busy), 64'(0));

    // Silent memory, TIMEOUT=8, then a late word drained in IDLE
    go(); start = 1'b1; mem_silent = 1'b1; look();
    go(); start = 1'b0; look();
    chk("t4_cmd_en", 64'(cmd_en), 64'(1));
    chk("t4_cmd_addr", 64'(cmd_addr), 64'(31'h100C));
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t4_wait_busy", 64'(busy), 64'(1));
      chk("t4_wait_err", 64'(err), 64'(0));
      chk("t4_wait_rdy", 64'(mc_rd_rdy), 64'(0));
      chk("t4_wait_valid", 64'(out_valid), 64'(0));
    end
    cyc();
    chk("t4_err", 64'(err), 64'(1));
    chk("t4_mc_rd_rdy", 64'(mc_rd_rdy), 64'(1));
    chk("t4_count", 64'(rd_count), 64'(12));
    cyc();
    chk("t4_idle", 64'(busy), 64'(0));
    chk("t4_err_sticky", 64'(err), 64'(1));
    cyc();
    go(); inj_data = 32'hDEAD_BEEF; inj_req = inj_req + 1; look();
    go(); start = 1'b1; look();
    chk("t4_drain_rd_en", 64'(rd_en), 64'(1));
    chk("t4_drain_busy", 64'(busy), 64'(0));
    chk("t4_drain_valid", 64'(out_valid), 64'(0));
    chk("t4_drain_cmd_en", 64'(cmd_en), 64'(0));
    go(); mem_silent = 1'b0; look();
    chk("t4_latch_rd_en", 64'(rd_en), 64'(0));
    go(); start = 1'b0; look();
    chk("t4_next_cmd_en", 64'(cmd_en), 64'(1));
    chk("t4_next_addr", 64'(cmd_addr), 64'(31'h1010));
    cyc();
    cyc();
    chk("t4_next_data", 64'(out_data), 64'(32'hA5A5_1010));
    chk("t4_next_valid", 64'(out_valid), 64'(1));
    cyc();
    chk("t4_next_rdy", 64'(mc_rd_rdy), 64'(1));
    chk("t4_next_count", 64'(rd_count), 64'(13));
    chk("t4_next_err", 64'(err), 64'(1));
    cyc();

    // Reset while waiting; stale word arrives two cycles after reset
    go(); start = 1'b1; mem_lat = 3; look();
    go(); start = 1'b0; look();
    chk("t5_cmd_addr", 64'(cmd_addr), 64'(31'h1014));
    go(); rst = 1'b1; look();
    chk("t5_wait_busy", 64'(busy), 64'(1));
    go(); rst = 1'b0; look();
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_err", 64'(err), 64'(0));
    chk("t5_rst_count", 64'(rd_count), 64'(0));
    chk("t5_rst_data", 64'(out_data), 64'(0));
    chk("t5_rst_addr", 64'(cmd_addr), 64'(0));
    chk("t5_rst_rd_en", 64'(rd_en), 64'(0));
    chk("t5_rst_cmd_en", 64'(cmd_en), 64'(0));
    go(); start = 1'b1; mem_lat = 1; look();
    chk("t5_stale_rd_en", 64'(rd_en), 64'(1));
    chk("t5_stale_busy", 64'(busy), 64'(0));
    chk("t5_stale_valid", 64'(out_valid), 64'(0));
    cyc();
    chk("t5_latch_rd_en", 64'(rd_en), 64'(0));
    go(); start = 1'b0; look();
    chk("t5_cmd_en", 64'(cmd_en), 64'(1));
    chk("t5_new_addr", 64'(cmd_addr), 64'(31'h1000));
    cyc();
    chk("t5_rd_en", 64'(rd_en), 64'(1));
    cyc();
    chk("t5_out_valid", 64'(out_valid), 64'(1));
    chk("t5_out_data", 64'(out_data), 64'(32'hA5A5_1000));
    cyc();
    chk("t5_mc_rd_rdy", 64'(mc_rd_rdy), 64'(1));
    chk("t5_count", 64'(rd_count), 64'(1));
    cyc();
    chk("t5_idle", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
